// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - writeback requester handshakes and register file write port
interface regfile_write_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req1_valid;
    logic        req1_ready;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  rf_we, rf_a3, rf_wd
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output rf_we, rf_a3, rf_wd
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin register file write arbiter with clear sequencer
// Optional read forwarding from the registered write stage: RFARB_FWD_EN.
module regfile_write_arbiter (
    input  logic                          clk,
    input  logic                          rst,
    regfile_write_arbiter_if.slave        bus,
    input  logic                          clr_start,
    output logic                          clr_busy
`ifdef RFARB_FWD_EN
    ,
    input  logic [4:0]                    rs1,
    input  logic [4:0]                    rs2,
    input  logic [31:0]                   rd1_in,
    input  logic [31:0]                   rd2_in,
    output logic [31:0]                   rd1_out,
    output logic [31:0]                   rd2_out
`endif
);

    typedef enum logic {ARB, CLEAR} state_t;

    state_t      state_q, state_d;
    logic        rr_q, rr_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        rf_we_q, rf_we_d;
    logic [4:0]  rf_a3_q, rf_a3_d;
    logic [31:0] rf_wd_q, rf_wd_d;
    logic        clr_busy_q, clr_busy_d;
    logic        grant0, grant1;

    // rr_q names the requester favoured on a tie; it flips to the other one after each grant.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst && state_q == ARB) begin
            grant0 = bus.req0_valid && (!bus.req1_valid || !rr_q);
            grant1 = bus.req1_valid && (!bus.req0_valid ||  rr_q);
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        rf_we_d = 1'b0;
        rf_a3_d = rf_a3_q;
        rf_wd_d = rf_wd_q;
        case (state_q)
            ARB: begin
                if (grant0) begin
                    rf_we_d = (bus.req0_addr != 5'd0);
                    rf_a3_d = bus.req0_addr;
                    rf_wd_d = bus.req0_data;
                    rr_d    = 1'b1;
                end else if (grant1) begin
                    rf_we_d = (bus.req1_addr != 5'd0);
                    rf_a3_d = bus.req1_addr;
                    rf_wd_d = bus.req1_data;
                    rr_d    = 1'b0;
                end
                if (clr_start) begin
                    state_d = CLEAR;
                    cnt_d   = 5'd1;
                end
            end
            CLEAR: begin
                rf_we_d = 1'b1;
                rf_a3_d = cnt_q;
                rf_wd_d = 32'd0;
                cnt_d   = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
        clr_busy_d = (state_d == CLEAR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ARB;
            rr_q       <= 1'b0;
            cnt_q      <= 5'd0;
            rf_we_q    <= 1'b0;
            rf_a3_q    <= 5'd0;
            rf_wd_q    <= 32'd0;
            clr_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
            rf_we_q    <= rf_we_d;
            rf_a3_q    <= rf_a3_d;
            rf_wd_q    <= rf_wd_d;
            clr_busy_q <= clr_busy_d;
        end
    end

    assign bus.rf_we = rf_we_q;
    assign bus.rf_a3 = rf_a3_q;
    assign bus.rf_wd = rf_wd_q;
    assign clr_busy  = clr_busy_q;

`ifdef RFARB_FWD_EN
    // Bypass the write the register file is capturing this cycle; x0 is never forwarded.
    assign rd1_out = (rf_we_q && rf_a3_q == rs1 && rs1 != 5'd0) ? rf_wd_q : rd1_in;
    assign rd2_out = (rf_we_q && rf_a3_q == rs2 && rs2 != 5'd0) ? rf_wd_q : rd2_in;
`endif

endmodule
